cl_serie_ctrl: RTL and testbench

//  Bit-serial logic unit controller. Applies a 2-bit logic operation to WIDTH-bit operands

---
 rtl/cl_serie_ctrl_pkg.sv | 26 ++
 rtl/cl_serie_ctrl_if.sv | 25 ++
 rtl/cl_serie_ctrl_cell.sv | 21 ++
 rtl/cl_serie_ctrl.sv | 99 +++++++++
 tb/tb_cl_serie_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/cl_serie_ctrl_pkg.sv
// Shared types for the bit-serial logic unit: cell operation codes, controller states
// and the counter sizing helper.
package cl_serie_ctrl_pkg;

    // Operation order matches the select input of the cl cell mux.
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter must hold WIDTH-1 and never collapse to zero bits.
    function automatic int cntWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/cl_serie_ctrl_if.sv
// Requester-side handshake and operand bus of the bit-serial logic unit.
interface cl_serie_ctrl_if
    import cl_serie_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, op,
        input  result, busy, done
    );

    modport slave (
        input  start, a, b, op,
        output result, busy, done
    );

endinterface

// File: rtl/cl_serie_ctrl_cell.sv
// Single-bit cl logic cell: a 4:1 mux over AND, OR, XOR and NOT(a).
module cl_serie_ctrl_cell
    import cl_serie_ctrl_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  op_t  i_s,
    output logic o_y
);

    always_comb begin
        o_y = 1'b0;
        case (i_s)
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            default: o_y = ~i_a;
        endcase
    end

endmodule

// File: rtl/cl_serie_ctrl.sv
// Bit-serial logic unit controller: feeds latched operands LSB first through one cl cell
// and reassembles the result, with a start/busy/done handshake.
module cl_serie_ctrl
    import cl_serie_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic           clk,
    input  logic           rst_n,
    cl_serie_ctrl_if.slave bus
);

    localparam int CW = cntWidth(WIDTH);

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic [WIDTH-1:0] r_resSh;
    op_t              r_op;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_lastBit;
    logic             w_cellOut;

    assign w_lastBit  = (r_cnt == CW'(WIDTH - 1));
    assign bus.result = r_resSh;

    cl_serie_ctrl_cell u_cell (
        .i_a (r_aSh[0]),
        .i_b (r_bSh[0]),
        .i_s (r_op),
        .o_y (w_cellOut)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Start is honoured in IDLE and DONE only, so DONE can chain straight into RUN.
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.busy = 1'b1;
                if (w_lastBit) begin
                    w_stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_stateNext = ST_RUN;
                end else begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aSh   <= '0;
            r_bSh   <= '0;
            r_resSh <= '0;
            r_op    <= OP_AND;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_aSh <= bus.a;
            r_bSh <= bus.b;
            r_op  <= op_t'(bus.op);
            r_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_aSh   <= r_aSh >> 1;
            r_bSh   <= r_bSh >> 1;
            r_resSh <= WIDTH'({w_cellOut, r_resSh} >> 1);
            r_cnt   <= r_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_cl_serie_ctrl.sv
// Directed bench for cl_serie_ctrl: an 8-bit and a 1-bit instance sharing clock and reset,
// driven on falling edges and sampled on falling edges.
module tb_cl_serie_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cl_serie_ctrl_if #(.WIDTH(8)) bus8 ();
    cl_serie_ctrl_if #(.WIDTH(1)) bus1 ();

    cl_serie_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    cl_serie_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single cycle; returns at the first falling edge inside RUN.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.op    = op;
        @(negedge clk);
        bus8.start = 1'b0;
        checkOutput("busy after start", {31'd0, bus8.busy}, 32'd1);
    endtask

    task automatic waitDone(input string tag, input int expLat, input logic [7:0] expRes);
        int n;
        n = 0;
        while (bus8.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " latency"}, n, expLat);
        checkOutput({tag, " result"}, {24'd0, bus8.result}, {24'd0, expRes});
        checkOutput({tag, " busy in done"}, {31'd0, bus8.busy}, 32'd0);
    endtask

    task automatic checkIdle(input string tag);
        @(negedge clk);
        checkOutput({tag, " done pulse ends"}, {31'd0, bus8.done}, 32'd0);
        checkOutput({tag, " busy idle"}, {31'd0, bus8.busy}, 32'd0);
    endtask

    logic [1:0] opTab  [3] = '{2'b01, 2'b10, 2'b11};
    logic [7:0] resTab [3] = '{8'hBD, 8'h99, 8'h5A};

    initial begin
        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.op    = '0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        bus1.op    = '0;
        #12;
        checkOutput("reset result", {24'd0, bus8.result}, 32'd0);
        checkOutput("reset busy", {31'd0, bus8.busy}, 32'd0);
        checkOutput("reset done", {31'd0, bus8.done}, 32'd0);
        checkOutput("reset w1 busy", {31'd0, bus1.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'hA5, 8'h3C, 2'b00);
        waitDone("and", 8, 8'h24);
        checkIdle("and");
        checkOutput("and result held", {24'd0, bus8.result}, 32'h24);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'hA5, 8'h3C, opTab[i]);
            waitDone($sformatf("op%0d", opTab[i]), 8, resTab[i]);
            checkIdle($sformatf("op%0d", opTab[i]));
        end

        applyStimulus(8'hA5, 8'h3C, 2'b00);
        repeat (2) @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'hFF;
        bus8.b     = 8'hFF;
        bus8.op    = 2'b01;
        @(negedge clk);
        bus8.start = 1'b0;
        checkOutput("ignored start busy", {31'd0, bus8.busy}, 32'd1);
        waitDone("ignored", 5, 8'h24);
        checkIdle("ignored");

        applyStimulus(8'hA5, 8'h3C, 2'b00);
        repeat (4) @(negedge clk);
        checkOutput("busy before reset", {31'd0, bus8.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset result", {24'd0, bus8.result}, 32'd0);
        checkOutput("async reset busy", {31'd0, bus8.busy}, 32'd0);
        checkOutput("async reset done", {31'd0, bus8.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h0F, 8'hF0, 2'b01);
        waitDone("post reset", 8, 8'hFF);
        checkIdle("post reset");

        applyStimulus(8'hA5, 8'h3C, 2'b00);
        waitDone("b2b first", 8, 8'h24);
        bus8.start = 1'b1;
        bus8.a     = 8'hF0;
        bus8.b     = 8'h0F;
        bus8.op    = 2'b10;
        @(negedge clk);
        bus8.start = 1'b0;
        checkOutput("b2b no idle busy", {31'd0, bus8.busy}, 32'd1);
        checkOutput("b2b no idle done", {31'd0, bus8.done}, 32'd0);
        waitDone("b2b second", 8, 8'hFF);
        checkIdle("b2b second");

        @(negedge clk);
        bus1.start = 1'b1;
        bus1.a     = 1'b1;
        bus1.b     = 1'b0;
        bus1.op    = 2'b10;
        @(negedge clk);
        bus1.start = 1'b0;
        checkOutput("w1 xor busy", {31'd0, bus1.busy}, 32'd1);
        checkOutput("w1 xor early done", {31'd0, bus1.done}, 32'd0);
        @(negedge clk);
        checkOutput("w1 xor done", {31'd0, bus1.done}, 32'd1);
        checkOutput("w1 xor result", {31'd0, bus1.result}, 32'd1);
        @(negedge clk);
        checkOutput("w1 xor pulse ends", {31'd0, bus1.done}, 32'd0);
        bus1.start = 1'b1;
        bus1.op    = 2'b11;
        @(negedge clk);
        bus1.start = 1'b0;
        @(negedge clk);
        checkOutput("w1 not done", {31'd0, bus1.done}, 32'd1);
        checkOutput("w1 not result", {31'd0, bus1.result}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
